// File: rtl/dl_pkg.sv
// Constants and FSM encoding shared between the data-loader controller and the
// coefficient/error MAC consumer.
package dl_pkg;

    localparam int N    = 150;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int ACCW = 2 * DW + $clog2(N);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiplier feeding an accumulator. The product of one cycle
// is folded into the accumulator on the next, so the caller drains once at the end.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     drain_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [2*DATA_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       pv_q, pv_d;

    always_comb begin
        prod_d = prod_q;
        pv_d   = en_i;
        acc_d  = acc_q;
        if (en_i) begin
            prod_d = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
        end
        // pv_q marks prod_q as holding a product from this pass, not a stale one
        if (clr_i) begin
            acc_d = '0;
            pv_d  = 1'b0;
        end else if (pv_q && (en_i || drain_i)) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
            pv_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            pv_q   <= pv_d;
        end
    end

    assign sum_o = acc_q + ACC_W'(prod_q);

endmodule

// File: rtl/coef_err_mac.sv
// Captures coefficient and error streams into register files, then runs one
// sum(coef[i]*err[i]) pass and offers the result on a valid/ready handshake.
module coef_err_mac
    import dl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_cc,
    input  logic                   en_err,
    input  logic [AW-1:0]          cnt_in,
    input  logic signed [DW-1:0]   data_in,
    output logic                   busy,
    output logic signed [ACCW-1:0] result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   protocol_err
);

    logic signed [DW-1:0]   coef_q [N];
    logic signed [DW-1:0]   err_q  [N];

    state_e                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic signed [ACCW-1:0] result_q, result_d;
    logic                   perr_q, perr_d;

    logic                   in_range, any_wr, bad_wr;
    logic                   wr_cc, wr_err, trigger, last_idx;
    logic                   mac_clr, mac_en, mac_drain;
    logic signed [ACCW-1:0] mac_sum;

    assign in_range = (cnt_in < AW'(N));
    assign any_wr   = en_cc || en_err;
    assign bad_wr   = any_wr && (busy || !in_range || (en_cc && en_err));
    // Coefficient wins a simultaneous write; the dropped error write cannot trigger
    assign wr_cc    = en_cc && !busy && in_range;
    assign wr_err   = en_err && !en_cc && !busy && in_range;
    assign trigger  = wr_err && (cnt_in == AW'(N - 1));
    assign last_idx = (idx_q == AW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_cc)  coef_q[cnt_in] <= data_in;
            if (wr_err) err_q[cnt_in]  <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (trigger)      state_d = COMPUTE;
            COMPUTE: if (last_idx)     state_d = DRAIN;
            DRAIN:                     state_d = DONE;
            DONE:    if (result_ready) state_d = LOAD;
            default:                   state_d = LOAD;
        endcase
    end

    always_comb begin
        busy         = (state_q != LOAD);
        result_valid = (state_q == DONE);
        mac_clr      = trigger;
        mac_en       = (state_q == COMPUTE);
        mac_drain    = (state_q == DRAIN);
    end

    always_comb begin
        idx_d    = idx_q;
        result_d = result_q;
        perr_d   = perr_q || bad_wr;
        if (trigger) begin
            idx_d = '0;
        end else if (state_q == COMPUTE) begin
            idx_d = last_idx ? '0 : idx_q + AW'(1);
        end
        if (state_q == DRAIN) begin
            result_d = mac_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            result_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            result_q <= result_d;
            perr_q   <= perr_d;
        end
    end

    mac_unit #(
        .DATA_W (DW),
        .ACC_W  (ACCW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .drain_i (mac_drain),
        .a_i     (coef_q[idx_q]),
        .b_i     (err_q[idx_q]),
        .sum_o   (mac_sum)
    );

    assign result       = result_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_coef_err_mac.sv
// Bench for coef_err_mac: a sum-of-products model driven by the same write calls,
// a per-cycle compare process, and literal checks for the directed scenarios.
module tb_coef_err_mac;
    import dl_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en_cc = 1'b0;
    logic                   en_err = 1'b0;
    logic [AW-1:0]          cnt_in = '0;
    logic signed [DW-1:0]   data_in = '0;
    logic                   result_ready = 1'b1;
    logic                   busy, result_valid, protocol_err;
    logic signed [ACCW-1:0] result;

    int errors = 0;
    int checks = 0;

    int coef_m [N];
    int err_m  [N];
    int cv [N];
    int ev [N];
    bit busy_m = 0, valid_m = 0, perr_m = 0, chk_en = 0;
    int cd = 0;
    int exp_res = 0;

    coef_err_mac dut (
        .clk          (clk),
        .rst          (rst),
        .en_cc        (en_cc),
        .en_err       (en_err),
        .cnt_in       (cnt_in),
        .data_in      (data_in),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += coef_m[i] * err_m[i];
        return s;
    endfunction

    // Effect of one clock edge on the observable behaviour
    task automatic model_apply(input bit cc, input bit er, input int cnt, input int d);
        bit b = busy_m;
        bit v = valid_m;
        if (v && result_ready) begin
            busy_m  = 0;
            valid_m = 0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) valid_m = 1;
        end
        if (cc || er) begin
            if (b || cnt >= N || (cc && er)) perr_m = 1;
            if (!b && cnt < N) begin
                if (cc) coef_m[cnt] = d;
                else begin
                    err_m[cnt] = d;
                    if (cnt == N - 1) begin
                        exp_res = model_sum();
                        busy_m  = 1;
                        cd      = N + 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit cc = 0, input bit er = 0, input int cnt = 0, input int d = 0);
        en_cc   = cc;
        en_err  = er;
        cnt_in  = cnt[AW-1:0];
        data_in = d[DW-1:0];
        @(posedge clk);
        #1;
        model_apply(cc, er, cnt, d);
        en_cc  = 0;
        en_err = 0;
    endtask

    task automatic do_reset(input int n);
        chk_en = 0;
        rst    = 1;
        repeat (n) @(posedge clk);
        #1;
        busy_m  = 0;
        valid_m = 0;
        perr_m  = 0;
        cd      = 0;
        rst     = 0;
        chk_en  = 1;
    endtask

    task automatic load_pass();
        for (int i = 0; i < N; i++) cyc(1, 0, i, cv[i]);
        for (int i = 0; i < N; i++) cyc(0, 1, i, ev[i]);
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!result_valid && lat < 400) begin
            cyc();
            lat++;
        end
        if (lat >= 400) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no result_valid expected result_valid within 400 cycles", name);
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, busy_m);
            check("result_valid", result_valid, valid_m);
            check("protocol_err", protocol_err, perr_m);
            if (valid_m) check("result", result, exp_res);
        end
    end

    initial begin
        int lat;
        do_reset(3);
        check("reset_busy", busy, 0);
        check("reset_valid", result_valid, 0);
        check("reset_perr", protocol_err, 0);
        check("reset_result", result, 0);

        // 1: all-ones by all-twos, latency pinned
        for (int i = 0; i < N; i++) begin cv[i] = 1; ev[i] = 2; end
        load_pass();
        wait_valid("t1", lat);
        // consumer samples valid at the edge after it appears
        check("t1_latency", lat + 1, 152);
        check("t1_result", result, 300);
        cyc();
        check("t1_valid_drop", result_valid, 0);

        // 2: extreme negative operands, then mixed sign
        for (int i = 0; i < N; i++) begin cv[i] = -128; ev[i] = -128; end
        load_pass();
        wait_valid("t2a", lat);
        check("t2a_result", result, 2457600);
        cyc();
        for (int i = 0; i < N; i++) begin cv[i] = -1; ev[i] = 127; end
        load_pass();
        wait_valid("t2b", lat);
        check("t2b_result", result, -19050);
        cyc();

        // 3: ramp with consumer stall
        for (int i = 0; i < N; i++) begin
            cv[i] = (i < 128) ? i : 0;
            ev[i] = (i < 128) ? 1 : 0;
        end
        result_ready = 0;
        load_pass();
        wait_valid("t3", lat);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("t3_hold_valid", result_valid, 1);
            check("t3_hold_result", result, 8128);
        end
        result_ready = 1;
        cyc();
        check("t3_valid_drop", result_valid, 0);

        // 4: simultaneous enables and out-of-range index
        for (int i = 0; i < N; i++) cyc(1, 0, i, 0);
        for (int i = 0; i < N - 1; i++) cyc(0, 1, i, (i == 5) ? 2 : 0);
        cyc(1, 1, 5, 51);
        check("t4_perr", protocol_err, 1);
        cyc(0, 1, 200, 7);
        check("t4_range_busy", busy, 0);
        cyc(1, 1, N - 1, 0);
        check("t4_both_no_trigger", busy, 0);
        cyc(0, 1, N - 1, 0);
        wait_valid("t4", lat);
        check("t4_result", result, 102);
        cyc();

        // 5: reset in the middle of a pass
        for (int i = 0; i < N; i++) begin cv[i] = 1; ev[i] = 2; end
        load_pass();
        repeat (50) cyc();
        do_reset(1);
        check("t5_busy", busy, 0);
        check("t5_valid", result_valid, 0);
        check("t5_perr", protocol_err, 0);
        repeat (160) cyc();
        load_pass();
        wait_valid("t5", lat);
        check("t5_result", result, 300);
        cyc();

        // 6: writes while busy are ignored
        for (int i = 0; i < N; i++) begin cv[i] = rnd8(); ev[i] = rnd8(); end
        load_pass();
        for (int k = 0; k < 5; k++) cyc(0, 1, $urandom_range(0, N - 1), rnd8());
        cyc(1, 0, 3, rnd8());
        check("t6_perr", protocol_err, 1);
        wait_valid("t6", lat);
        check("t6_result", result, exp_res);
        cyc();

        // random passes with illegal writes interleaved and random stalls
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < N; i++) begin cv[i] = rnd8(); ev[i] = rnd8(); end
            result_ready = 0;
            for (int i = 0; i < N; i++) begin
                cyc(1, 0, i, cv[i]);
                if ($urandom_range(0, 7) == 0) cyc(1, 1, $urandom_range(0, N - 1), rnd8());
            end
            for (int i = 0; i < N - 1; i++) begin
                cyc(0, 1, i, ev[i]);
                if ($urandom_range(0, 7) == 0) cyc(0, 1, $urandom_range(N, 255), rnd8());
            end
            cyc(0, 1, N - 1, ev[N-1]);
            wait_valid("rand", lat);
            repeat ($urandom_range(0, 5)) cyc();
            result_ready = 1;
            cyc();
            check("rand_valid_drop", result_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
